// File: rtl/bias_add_9.sv
// bias_add_9: adds the per-channel bias to each layer-9 accumulator sample, saturates to OUT_W, ap_fifo out.
`ifndef COEFF_WIDTH
`define COEFF_WIDTH 16
`endif
`ifndef KERN_S_K_9
`define KERN_S_K_9 16
`endif
module bias_add_9 #(
  parameter int ACC_W      = 32,
  parameter int COEFF_W    = `COEFF_WIDTH,
  parameter int OUT_W      = 16,
  parameter int NUM_CH     = `KERN_S_K_9,
  parameter int PIX_PER_CH = 64
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic [ACC_W-1:0]   input_V_dout,
  input  logic               input_V_empty_n,
  output logic               input_V_read,
  input  logic [COEFF_W-1:0] bias_V_dout,
  input  logic               bias_V_empty_n,
  output logic               bias_V_read,
  output logic [OUT_W-1:0]   output_V_din,
  input  logic               output_V_full_n,
  output logic               output_V_write
);
  localparam int PW = PIX_PER_CH > 1 ? $clog2(PIX_PER_CH) : 1;
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W:0] SAT_LO = ~SAT_HI;
  typedef enum logic {LOAD, RUN} state_t;
  state_t                state_q, state_d;
  logic [PW-1:0]         pix_cnt_q, pix_cnt_d;
  logic [CW-1:0]         ch_cnt_q, ch_cnt_d;
  logic [COEFF_W-1:0]    bias_q, bias_d;
  logic                  out_valid_q, out_valid_d;
  logic [OUT_W-1:0]      out_q, out_d;
  logic                  accept, last_pix;
  logic signed [ACC_W:0] sum;
  logic [OUT_W-1:0]      sat;
  always_comb begin
    accept = state_q == RUN && input_V_empty_n && (!out_valid_q || output_V_full_n);
    last_pix = pix_cnt_q == PW'(PIX_PER_CH - 1);
    sum = {input_V_dout[ACC_W-1], input_V_dout} + {{(ACC_W+1-COEFF_W){bias_q[COEFF_W-1]}}, bias_q};
    sat = sum > SAT_HI ? SAT_HI[OUT_W-1:0] : sum < SAT_LO ? SAT_LO[OUT_W-1:0] : sum[OUT_W-1:0];
`ifdef BIAS_ADD_9_RELU_EN
    sat = sat[OUT_W-1] ? '0 : sat;
`endif
    input_V_read = accept;
    bias_V_read = ap_rst_n && state_q == LOAD && bias_V_empty_n;
    output_V_write = out_valid_q && output_V_full_n;
    output_V_din = out_q;
    state_d = bias_V_read ? RUN : (accept && last_pix) ? LOAD : state_q;
    pix_cnt_d = accept ? (last_pix ? '0 : pix_cnt_q + PW'(1)) : pix_cnt_q;
    ch_cnt_d = (accept && last_pix) ? (ch_cnt_q == CW'(NUM_CH - 1) ? '0 : ch_cnt_q + CW'(1)) : ch_cnt_q;
    bias_d = bias_V_read ? bias_V_dout : bias_q;
    out_valid_d = accept || (out_valid_q && !output_V_full_n);
    out_d = accept ? sat : out_q;
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= LOAD;
      pix_cnt_q   <= '0;
      ch_cnt_q    <= '0;
      bias_q      <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      ch_cnt_q    <= ch_cnt_d;
      bias_q      <= bias_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end
endmodule

// File: tb/tb_bias_add_9.sv
// tb_bias_add_9: randomized scoreboard bench for bias_add_9 with FIFO models on all three streams.
module tb_bias_add_9;
   localparam int ACC_W = 32, COEFF_W = 16, OUT_W = 16, NUM_CH = 2, PIX = 4;
   logic ap_clk = 1'b0, ap_rst_n = 1'b0;
   logic [ACC_W-1:0] input_V_dout = '0;
   logic input_V_empty_n = 1'b0, input_V_read;
   logic [COEFF_W-1:0] bias_V_dout = '0;
   logic bias_V_empty_n = 1'b0, bias_V_read;
   logic [OUT_W-1:0] output_V_din;
   logic output_V_full_n = 1'b1, output_V_write;

   bias_add_9 #(.ACC_W(ACC_W), .COEFF_W(COEFF_W), .OUT_W(OUT_W), .NUM_CH(NUM_CH), .PIX_PER_CH(PIX)) dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
      .input_V_dout(input_V_dout), .input_V_empty_n(input_V_empty_n), .input_V_read(input_V_read),
      .bias_V_dout(bias_V_dout), .bias_V_empty_n(bias_V_empty_n), .bias_V_read(bias_V_read),
      .output_V_din(output_V_din), .output_V_full_n(output_V_full_n), .output_V_write(output_V_write)
   );

   always #5 ap_clk = ~ap_clk;

   int errors = 0, checks = 0;
   logic [ACC_W-1:0] acc_fifo[$];
   logic [COEFF_W-1:0] bias_fifo[$];
   int bias_hist[$];
   logic [OUT_W-1:0] exp_q[$];
   logic [OUT_W-1:0] mon_e, din_s, hold;
   int n_acc = 0, cyc = 0, nbias = 0, nreads = 0, first_rd = -1, last_rd = -1;
   logic ra, rb, wr_s;
   bit rnd_full = 0;

   function automatic logic [OUT_W-1:0] model(longint a, longint b);
      longint s = a + b;
      longint hi = (longint'(1) << (OUT_W - 1)) - 1;
      if (s > hi) s = hi;
      if (s < -hi - 1) s = -hi - 1;
`ifdef BIAS_ADD_9_RELU_EN
      if (s < 0) s = 0;
`endif
      return OUT_W'(s);
   endfunction

   task automatic check(string name, longint act, longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic refresh();
      input_V_empty_n = acc_fifo.size() != 0;
      input_V_dout = acc_fifo.size() != 0 ? acc_fifo[0] : '0;
      bias_V_empty_n = bias_fifo.size() != 0;
      bias_V_dout = bias_fifo.size() != 0 ? bias_fifo[0] : '0;
   endtask

   task automatic model_bias(int b);
      bias_hist.push_back(b);
   endtask

   task automatic push_bias(int b);
      bias_fifo.push_back(COEFF_W'(b));
   endtask

   // expected value comes from the bias stream position: sample j belongs to bias j/PIX
   task automatic push_acc(longint v);
      acc_fifo.push_back(ACC_W'(v));
      exp_q.push_back(model(v, bias_hist[n_acc / PIX]));
      n_acc++;
   endtask

   task automatic step();
      #4;
      ra = input_V_read; rb = bias_V_read; wr_s = output_V_write; din_s = output_V_din;
      cyc++;
      if (rb) nbias++;
      if (ra) begin
         nreads++;
         if (first_rd < 0) first_rd = cyc;
         last_rd = cyc;
      end
      @(posedge ap_clk); #1;
      if (ra) void'(acc_fifo.pop_front());
      if (rb) void'(bias_fifo.pop_front());
      @(negedge ap_clk);
      refresh();
      if (rnd_full) output_V_full_n = 1'($urandom_range(0, 1));
   endtask

   task automatic drain(int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
      output_V_full_n = 1'b1;
      for (int i = 0; i < 4; i++) step();
      check("drain_left", exp_q.size(), 0);
   endtask

   initial forever begin
      @(negedge ap_clk); #4;
      if (ap_rst_n && output_V_write) begin
         if (exp_q.size() == 0) check("unexpected_write", 1, 0);
         else begin
            mon_e = exp_q.pop_front();
            check("out", $signed(output_V_din), $signed(mon_e));
         end
      end
   end

   initial begin
      model_bias(5); model_bias(-3);
      push_bias(5); push_bias(-3);
      for (int i = 0; i < 8; i++) push_acc(i);
      refresh();
      repeat (3) @(negedge ap_clk);
      check("rst_bias_read", bias_V_read, 0);
      check("rst_input_read", input_V_read, 0);
      check("rst_write", output_V_write, 0);
      check("rst_din", output_V_din, 0);
      ap_rst_n = 1'b1;
      drain(60);
      check("basic_bias_pops", nbias, 2);
      check("basic_reads", nreads, 8);
      check("basic_read_span", last_rd - first_rd, 8);

      model_bias(100); model_bias(-100); model_bias(3); model_bias(7);
      push_bias(100); push_bias(-100); push_bias(3); push_bias(7);
      for (int i = 0; i < 4; i++) push_acc(40000);
      for (int i = 0; i < 4; i++) push_acc(-40000);
      for (int i = 0; i < 4; i++) push_acc(-10);
      push_acc(32760); push_acc(32761); push_acc(-32775); push_acc(-32776);
      refresh();
      drain(100);

      model_bias(11); push_bias(11);
      for (int i = 0; i < 4; i++) push_acc(1000 + i);
      refresh();
      repeat (3) step();
      output_V_full_n = 1'b0;
      step();
      hold = din_s;
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_write", wr_s, 0);
         check("bp_din", din_s, hold);
         check("bp_read", ra, 0);
      end
      output_V_full_n = 1'b1;
      drain(60);

      model_bias(-50);
      for (int i = 0; i < 4; i++) push_acc(int'($urandom_range(0, 2000)) - 1000);
      refresh();
      for (int i = 0; i < 10; i++) begin
         step();
         check("starve_read", ra, 0);
      end
      push_bias(-50);
      refresh();
      drain(60);

      for (int c = 0; c < 2 * NUM_CH; c++) begin
         int b = int'($urandom_range(0, 65535)) - 32768;
         model_bias(b); push_bias(b);
         for (int i = 0; i < PIX; i++) push_acc(longint'($urandom_range(0, 80000)) - 40000);
      end
      refresh();
      rnd_full = 1;
      drain(400);
      rnd_full = 0;
      output_V_full_n = 1'b1;

      model_bias(9); push_bias(9);
      for (int i = 0; i < 4; i++) push_acc(100 + i);
      refresh();
      repeat (3) step();
      ap_rst_n = 1'b0;
      #1;
      check("mid_rst_din", output_V_din, 0);
      check("mid_rst_write", output_V_write, 0);
      check("mid_rst_input_read", input_V_read, 0);
      check("mid_rst_bias_read", bias_V_read, 0);
      acc_fifo.delete(); bias_fifo.delete(); exp_q.delete(); bias_hist.delete();
      n_acc = 0;
      refresh();
      @(negedge ap_clk);
      model_bias(-7); push_bias(-7);
      for (int i = 0; i < 4; i++) push_acc(20 + i);
      refresh();
      ap_rst_n = 1'b1;
      step();
      check("post_rst_first_bias_read", rb, 1);
      check("post_rst_first_input_read", ra, 0);
      drain(60);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/bias_add_9.md
Name: bias_add_9

Overview:
- Stage directly downstream of the layer-9 bias streamer.
- Consumes the layer-9 convolution accumulator stream and the per-channel bias stream.
- Adds the current channel's bias to every accumulator sample of that channel, saturates the sum to the activation width, and emits it on an ap_fifo-style output stream.
- Feeds the next layer's line buffer.

Parameters:
- ACC_W, 32, accumulator sample width (signed)
- COEFF_W, `coeff_width, bias word width (signed)
- OUT_W, 16, output activation width (signed)
- NUM_CH, `kern_s_k_9, output channels per frame, i.e. biases per frame
- PIX_PER_CH, 64, accumulator samples per channel

Ports:
- ap_clk  in  1  clock
- ap_rst_n  in  1  asynchronous active-low reset
- input_V_dout  in  ACC_W  accumulator sample, first-word-fall-through
- input_V_empty_n  in  1  accumulator FIFO has data
- input_V_read  out  1  pop accumulator FIFO
- bias_V_dout  in  COEFF_W  bias word, first-word-fall-through
- bias_V_empty_n  in  1  bias FIFO has data
- bias_V_read  out  1  pop bias FIFO
- output_V_din  out  OUT_W  biased, saturated sample
- output_V_full_n  in  1  downstream FIFO has space
- output_V_write  out  1  push to downstream FIFO

Behaviour:
- Reset (async assert, sync release on ap_clk):
  - state=LOAD; pix_cnt=0; ch_cnt=0; bias_reg=0; out_valid=0; out_reg=0.
  - All outputs 0 while reset is asserted.
- FSM, two states:
  - LOAD: bias_V_read = bias_V_empty_n. On a pop, bias_reg <= bias_V_dout and the state goes to RUN next cycle. No accumulator read in LOAD.
  - RUN: accept = input_V_empty_n && (!out_valid || output_V_full_n). input_V_read = accept. bias_V_read = 0.
- On accept:
  - out_reg <= sat_OUT_W(sext(input_V_dout, ACC_W+1) + sext(bias_reg, ACC_W+1)).
  - out_valid <= 1.
  - pix_cnt increments.
- Channel end: when pix_cnt == PIX_PER_CH-1 on accept:
  - pix_cnt <= 0; state <= LOAD.
  - ch_cnt <= (ch_cnt == NUM_CH-1) ? 0 : ch_cnt+1. This is a frame wrap; no other state changes.
- Saturation: the sum is computed in ACC_W+1 bits with no overflow.
  - Sum > 2^(OUT_W-1)-1 gives 2^(OUT_W-1)-1.
  - Sum < -2^(OUT_W-1) gives -2^(OUT_W-1).
  - Otherwise the sum is truncated to OUT_W bits.
- Output interface:
  - output_V_din = out_reg.
  - output_V_write = out_valid && output_V_full_n.
  - When write is asserted and no new accept occurs in the same cycle, out_valid <= 0.
- Latency: 1 cycle from input_V_read to output_V_write, given full_n=1.
- Throughput: 1 sample/cycle inside a channel, plus exactly one bubble cycle per channel for the bias load.
- Backpressure: while out_valid=1 and full_n=0, out_reg holds and input_V_read=0. No sample is lost or duplicated.
- Simultaneous events: a write and a new accept in the same cycle are allowed; out_reg is replaced with the new sample and out_valid stays 1.
- Draining across states: in LOAD the output register still drains. The first accept of the new channel cannot happen before bias_reg is updated.
- Empty FIFOs: with bias FIFO empty in LOAD, or accumulator FIFO empty in RUN, the block stalls with counters frozen.
- Reset mid-frame: all counters clear. The next bias popped is treated as channel 0.

Optional Feature:
- Macro: BIAS_ADD_9_RELU_EN.
- Defined: after saturation, negative results are forced to 0, so outputs fall in 0..2^(OUT_W-1)-1. Latency is unchanged.
- Undefined: signed saturated output as specified above.

Test Plan:
- Basic add: NUM_CH=2, PIX_PER_CH=4, biases {5,-3}, acc 0..7, full_n=1.
  - Required output: 5,6,7,8,1,2,3,4.
  - Exactly 2 bias pops; one bubble cycle between channels.
- Saturation: acc=40000, bias=100 gives 32767. acc=-40000, bias=-100 gives -32768.
  - With BIAS_ADD_9_RELU_EN, acc=-10, bias=3 gives 0.
- Backpressure: hold full_n=0 for 5 cycles mid-channel.
  - output_V_din stays stable and output_V_write=0.
  - input_V_read=0 after out_valid is set.
  - On release, all samples emerge in order with none dropped.
- Starvation: withhold the bias FIFO for 10 cycles at a channel boundary.
  - No input_V_read during that time.
  - Resume yields correct bias association.
- Frame wrap: run 2 full frames of NUM_CH channels.
  - ch_cnt returns to 0.
  - Second-frame outputs use biases NUM_CH..2*NUM_CH-1 from the stream.
- Reset mid-channel: assert ap_rst_n=0 at pix_cnt=2.
  - Outputs go to 0 immediately.
  - After release, the first bias pop occurs before any accumulator read.
